// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, oversampling ratio and the
// data-bit-count constants used by the RS-232 receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] NBITS_6 = 4'd6;
  localparam logic [3:0] NBITS_7 = 4'd7;
  localparam logic [3:0] NBITS_8 = 4'd8;

  // Any unsupported width falls back to a full byte.
  function automatic logic [3:0] norm_nbits(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      NBITS_6: r = NBITS_6;
      NBITS_7: r = NBITS_7;
      default: r = NBITS_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rs232_tx.sv
// RS-232 transmitter: start bit, 6-8 data bits LSB first, one stop bit, each
// bit lasting OVERSAMPLE baud ticks. Tx, TxBusy and TxDone are registered.
//
//   state | meaning
//   IDLE  | line high, waiting for TxStart & TxEn
//   START | driving the start bit (low)
//   DATA  | driving shift register bit 0, one bit per 16 ticks
//   STOP  | driving the stop bit (high), TxDone on its last tick
module uart_rs232_tx
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       TxEn,
  input  logic       TxStart,
  input  logic [7:0] TxData,
  input  logic [3:0] NBits,
  output logic       Tx,
  output logic       TxBusy,
  output logic       TxDone
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  uart_state_e state, state_nxt;
  logic [3:0]  tick_cnt, tick_cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [3:0]  nbits_q, nbits_nxt;
  logic        tx_nxt, busy_nxt, done_nxt;
  logic        tick_end;

  assign tick_end = Tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      nbits_q  <= NBITS_8;
      Tx       <= 1'b1;
      TxBusy   <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      nbits_q  <= nbits_nxt;
      Tx       <= tx_nxt;
      TxBusy   <= busy_nxt;
      TxDone   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    nbits_nxt    = nbits_q;
    tx_nxt       = Tx;
    busy_nxt     = TxBusy;
    done_nxt     = 1'b0;

    // The 4-bit tick counter wraps from 15 to 0 on its own at the bit boundary.
    if (state != IDLE && Tick) tick_cnt_nxt = tick_cnt + 4'd1;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (TxStart && TxEn) begin
          state_nxt    = START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          shreg_nxt    = TxData;
          nbits_nxt    = norm_nbits(NBits);
        end
      end
      START: begin
        if (tick_end) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (tick_end) begin
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt + 4'd1 == nbits_q) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt = shreg[1];
          end
        end
      end
      STOP: begin
        if (tick_end) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Bench for uart_rs232_tx: stimulus queues hand-computed frames, a monitor
// reconstructs each frame from Tx mid-bit samples and checks it on TxDone.
module tb_uart_rs232_tx;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Tick;
  logic       TxEn;
  logic       TxStart;
  logic [7:0] TxData;
  logic [3:0] NBits;
  logic       Tx;
  logic       TxBusy;
  logic       TxDone;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] bits;   // bit k = Tx level during bit period k (0 = start)
    int         ticks;  // ticks from acceptance to TxDone
  } exp_t;

  exp_t exp_q[$];

  uart_rs232_tx dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Tick   (Tick),
    .TxEn   (TxEn),
    .TxStart(TxStart),
    .TxData (TxData),
    .NBits  (NBits),
    .Tx     (Tx),
    .TxBusy (TxBusy),
    .TxDone (TxDone)
  );

  always #5 Clk = ~Clk;

  // One Tick every 4 clocks, changed just after the rising edge.
  initial begin
    int div;
    div  = 0;
    Tick = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      Tick = (div == 3);
      div  = (div + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    bit         in_frame;
    bit         tick_pend;
    bit         prev_tx;
    bit         prev_done;
    bit         ticked;
    int         cnt;
    logic [9:0] got;
    exp_t       e;
    in_frame  = 0;
    tick_pend = 0;
    prev_tx   = 1;
    prev_done = 0;
    cnt       = 0;
    got       = '0;
    forever begin
      @(negedge Clk);
      if (Rst_n !== 1'b1) begin
        in_frame  = 0;
        tick_pend = 0;
        prev_tx   = 1;
        prev_done = 0;
        continue;
      end
      ticked = in_frame && tick_pend;
      if (ticked) cnt++;
      if (!in_frame && prev_tx && Tx === 1'b0) begin
        check("frame_expected", exp_q.size() > 0, 1);
        check("busy_at_start", TxBusy, 1);
        in_frame = 1;
        cnt      = 0;
        got      = '0;
      end else if (in_frame) begin
        if (Tx !== prev_tx && !(ticked && cnt % 16 == 0))
          check("tx_edge_on_bit_boundary", cnt, (cnt / 16) * 16 + 16);
        if (ticked && cnt % 16 == 8 && cnt / 16 < 10) got[cnt / 16] = Tx;
      end
      if (TxDone === 1'b1) begin
        check("done_single_pulse", prev_done, 0);
        check("done_in_frame", in_frame, 1);
        check("busy_low_at_done", TxBusy, 0);
        if (in_frame && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_bits", got, e.bits);
          check("frame_ticks", cnt, e.ticks);
        end
        in_frame = 0;
      end
      prev_done = TxDone;
      prev_tx   = Tx;
      tick_pend = Tick;
    end
  end

  task automatic push(input logic [9:0] bits, input int ticks);
    exp_t e;
    e.bits  = bits;
    e.ticks = ticks;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] n, input logic [9:0] bits, input int ticks);
    @(negedge Clk);
    push(bits, ticks);
    TxData  = d;
    NBits   = n;
    TxEn    = 1'b1;
    TxStart = 1'b1;
    @(negedge Clk);
    TxStart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  i;
    bit  seen;
    seen = 0;
    for (i = 0; i < budget && !seen; i++) begin
      @(negedge Clk);
      if (TxDone === 1'b1) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    Rst_n   = 1'b0;
    TxEn    = 1'b1;
    TxStart = 1'b0;
    TxData  = '0;
    NBits   = 4'd8;
    repeat (3) @(negedge Clk);
    check("reset_tx", Tx, 1);
    check("reset_busy", TxBusy, 0);
    check("reset_done", TxDone, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // 0xA5, 8 bits: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 4'd8, 10'h34A, 160);
    wait_done("done_a5", 1000);

    send(8'hFF, 4'd6, 10'h0FE, 128);
    wait_done("done_n6", 1000);
    send(8'hFF, 4'd7, 10'h1FE, 144);
    wait_done("done_n7", 1000);
    send(8'h3C, 4'hF, 10'h278, 160);
    wait_done("done_nF", 1000);

    // Start strobe and data change while busy must not disturb the frame.
    send(8'hC3, 4'd8, 10'h386, 160);
    repeat (50) @(negedge Clk);
    TxData  = 8'h00;
    NBits   = 4'd6;
    TxStart = 1'b1;
    @(negedge Clk);
    TxStart = 1'b0;
    wait_done("done_c3", 1000);
    repeat (20) @(negedge Clk);
    check("no_queued_frame", TxBusy, 0);

    // TxStart held high: two frames, second starting right after TxDone.
    @(negedge Clk);
    push(10'h2AA, 160);
    push(10'h21E, 160);
    TxData  = 8'h55;
    NBits   = 4'd8;
    TxStart = 1'b1;
    @(negedge Clk);
    TxData  = 8'h0F;
    wait_done("done_55", 1000);
    @(negedge Clk);
    check("b2b_start_tx", Tx, 0);
    check("b2b_start_busy", TxBusy, 1);
    TxStart = 1'b0;
    wait_done("done_0f", 1000);

    // Reset during DATA aborts the frame immediately.
    send(8'hF0, 4'd8, 10'h3E0, 160);
    repeat (200) @(negedge Clk);
    check("busy_before_abort", TxBusy, 1);
    Rst_n = 1'b0;
    #1;
    check("abort_tx", Tx, 1);
    check("abort_busy", TxBusy, 0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    send(8'h5A, 4'd6, 10'h0B4, 128);
    wait_done("done_after_abort", 1000);

    // Disabled transmitter ignores start requests.
    @(negedge Clk);
    TxEn    = 1'b0;
    TxStart = 1'b1;
    repeat (20) @(negedge Clk);
    check("disabled_busy", TxBusy, 0);
    check("disabled_tx", Tx, 1);
    TxStart = 1'b0;

    // Dropping TxEn mid-frame lets the frame complete.
    send(8'h81, 4'd7, 10'h102, 144);
    repeat (20) @(negedge Clk);
    TxEn = 1'b0;
    wait_done("done_en_drop", 1000);
    TxEn = 1'b1;

    repeat (10) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rs232_tx.md
# uart_rs232_tx

Serial transmitter for the RS-232 link; the transmit-side counterpart of the 16x-oversampling UART receiver. It accepts a parallel byte with a start strobe and shifts a start bit, 6–8 data bits (LSB first) and one stop bit onto `Tx`. Each bit lasts exactly 16 pulses of the shared baud `Tick`. It sits between the IR command logic and the board's serial pin, driven by the same baud tick generator as the receiver.

## Interface
- `OVERSAMPLE`, 16, Tick pulses per bit period.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Tick`  in  1  baud enable, one `Clk` cycle wide, synchronous to `Clk`, 16 per bit.
- `TxEn`  in  1  transmitter enable; gates acceptance of new frames only.
- `TxStart`  in  1  start request, sampled each `Clk`.
- `TxData`  in  8  byte to send; bits `[NBits-1:0]` are transmitted.
- `NBits`  in  4  data bit count: 6, 7 or 8; any other value is treated as 8.
- `Tx`  out  1  serial line, registered, idle high.
- `TxBusy`  out  1  high from acceptance until the frame ends.
- `TxDone`  out  1  one-`Clk` pulse at end of stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `Tx`=1.
  - On a `Clk` edge with `TxStart & TxEn`: latch `TxData` into the shift register, latch effective `NBits`, clear tick counter and bit counter, go to START.
- START: `Tx`=0. After 16 Ticks, go to DATA.
- DATA:
  - `Tx` = shift register bit 0.
  - Every 16 Ticks: shift right, increment bit counter.
  - When the bit counter reaches latched `NBits`, go to STOP.
- STOP:
  - `Tx`=1.
  - After 16 Ticks: go to IDLE and pulse `TxDone`.
- `TxStart` is ignored while busy; there is no queueing.
- `TxData`/`NBits` changes after acceptance do not affect the frame in flight.
- Deasserting `TxEn` mid-frame does not abort the frame; it completes normally.
- Tick counter: 4 bits. Terminal count 15 ends a bit and wraps to 0.
- Bit counter: 4 bits, compared with latched `NBits`.

## Timing
- Reset values: `Tx`=1, `TxBusy`=0, `TxDone`=0, state IDLE, counters 0.
- Reset mid-frame returns `Tx` high immediately (asynchronous) and discards the frame.
- Acceptance latency:
  - `Tx` falls and `TxBusy` rises on the same `Clk` edge that samples `TxStart`.
  - A `Tick` coincident with acceptance is not counted.
- Frame length: exactly 16×(`NBits`+2) Ticks from acceptance to `TxDone`.
- Each `Tx` transition occurs on the `Clk` edge that counts the 16th Tick of the previous bit.
- `TxDone` is high for exactly one `Clk` cycle. On that same edge, `TxBusy` falls and state is IDLE.
- Back-to-back frames:
  - `TxStart` held high is accepted on the cycle after `TxDone`.
  - `TxStart` asserted during the `TxDone` cycle is accepted on that cycle's edge.
  - No idle gap beyond one `Clk` is required.
- Between Ticks all outputs hold.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/STOP), shared with the receiver;
  - `OVERSAMPLE`=16;
  - NBits constants 6/7/8 and the normalisation function (invalid → 8).
- No sub-module. Tick counter, bit counter and shift register stay inline. The baud tick generator remains a separate sibling block feeding both rx and tx.

## Test plan
- Reset, then `NBits`=8, `TxData`=0xA5, one `TxStart` → `Tx` sequence per 16 Ticks is 0,1,0,1,0,0,1,0,1,1. `TxDone` pulses once after 160 Ticks.
- `NBits`=6, `TxData`=0xFF → six 1 data bits; `TxDone` after 128 Ticks. `NBits`=7 gives 144 Ticks. `NBits`=0xF gives 160 Ticks.
- `TxStart` pulsed mid-frame and `TxData` changed to 0x00 → frame unaltered, no second frame.
- `TxStart` held high, `TxData`=0x55 then 0x0F → two frames; second start bit begins the cycle after the first `TxDone`.
- `Rst_n` low during DATA → `Tx`=1 and `TxBusy`=0 immediately, with no `TxDone`. The next `TxStart` sends a full clean frame.
- `TxEn`=0 with `TxStart` → no activity. `TxEn` dropped mid-frame → frame completes and `TxDone` pulses.
